wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbiter for the single register-file write port. It shares the port between the pipeline write-back stage and one multi-cycle unit (divider/serial load) that returns results out of band. Multi-cycle results are held in a 2-entry buffer and drained into idle write-port cycles, with a starvation stall towards the pipeline. It also reports pending-write hazards on the buffered destination addresses to decode.

## Interface
- ADDR_W, 4, register address width (matches the register address bus)
- DATA_W, 16, register data width
- EMPTY_ADDR, 4'b1111, "no destination" address; never written
- STARVE_LIMIT, 4, cycles the buffer head may wait before stall_req; range 1..15

- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- pipe_we  in  1  WB-stage write request; no backpressure, always granted
- pipe_addr  in  ADDR_W  WB-stage destination
- pipe_data  in  DATA_W  WB-stage data
- mc_valid  in  1  multi-cycle result valid
- mc_addr  in  ADDR_W  multi-cycle destination
- mc_data  in  DATA_W  multi-cycle data
- mc_ready  out  1  buffer can accept; handshake when mc_valid & mc_ready
- q_addr_a, q_addr_b  in  ADDR_W  decode source-register queries
- q_busy  out  1  combinational: a query matches a live buffered entry
- stall_req  out  1  registered: freeze pipeline, insert WB bubbles
- rf_we  out  1  registered register-file write enable
- rf_addr  out  ADDR_W  registered write address
- rf_data  out  DATA_W  registered write data

## Operation
- Buffer: 2-entry in-order FIFO (head = entry 0), each entry {valid, addr, data}; count 0..2.
- mc_ready = (count != 2), derived from state only. No acceptance when full, even in a drain cycle.
- Pipeline write is "real" when pipe_we=1 and pipe_addr != EMPTY_ADDR.
- Per-cycle grant, priority order:
  1. Real pipeline write: rf_* <= {1, pipe_addr, pipe_data}.
  2. Else, if head valid: rf_* <= {1, head.addr, head.data}; pop head.
  3. Else: rf_we <= 0, rf_addr <= EMPTY_ADDR, rf_data holds.
- An entry accepted this cycle is never drained in the same cycle.
- Accept and pop in the same cycle with count=1: the new entry becomes head and count stays 1.
- WAW kill: a real pipeline write kills every buffered entry with the same addr in that cycle. It also kills an incoming mc result with the same addr (handshake still completes, nothing stored).
- Surviving entries compact toward the head.
- An mc result with mc_addr == EMPTY_ADDR is accepted and discarded.
- q_busy = any valid entry whose addr equals q_addr_a or q_addr_b (EMPTY_ADDR queries never match). It excludes the incoming mc result and the rf_* stage.
- Starvation counter (4-bit, saturating):
  - increments each cycle the head is valid and not granted;
  - clears on head grant, head kill, or empty buffer.
  - stall_req <= 1 when counter reaches STARVE_LIMIT; it clears the cycle after the head is granted or killed.
- Pipeline contract: pipe_we=0 from the cycle after stall_req rises. If a real pipe_we still arrives, it keeps priority.

## Timing
- Reset (rst=0, asynchronous): count=0, all entries invalid, counter=0, rf_we=0, rf_addr=EMPTY_ADDR, rf_data=0, stall_req=0, mc_ready=1.
- Reset mid-operation discards buffered results without writing them.
- Pipeline write latency: 1 cycle (request at edge N, rf_we high after edge N+1).
- mc handshake to rf_we: minimum 2 cycles.
- Buffer drains at most one entry per cycle.
- With STARVE_LIMIT=L and continuous pipe writes, stall_req rises L+1 cycles after the head becomes valid.

## Test plan
- Reset, then idle: rf_we=0, rf_addr=4'hF, mc_ready=1, stall_req=0, q_busy=0.
- mc {addr=3, data=16'h1234} accepted at cycle 0 with no pipe writes: rf_we=1, rf_addr=3, rf_data=16'h1234 visible after edge 2; buffer empty.
- Accept addr=2 and addr=5 while pipe_we=1 on addr=1: mc_ready=0 with count=2. q_addr_a=5 gives q_busy=1. Entries drain in order 2 then 5 once pipe_we drops.
- Buffered addr=4, then pipe write to addr=4 with data 16'hBEEF: the entry is killed, rf_data=16'hBEEF, and the stale value is never written.
- STARVE_LIMIT=4, buffered entry, pipe_we=1 every cycle: stall_req=1 after 5 cycles. With pipe_we=0 the next cycle, the entry is written and stall_req clears one cycle after the grant.
- Assert rst mid-operation with count=2: outputs return to reset values immediately, and neither entry is written after release.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the pipeline
//   write-back stage and one multi-cycle unit. Multi-cycle results are held
//   in a 2-entry in-order buffer and drained into cycles the pipeline leaves
//   idle. A starvation counter raises stall_req when the buffer head waits
//   too long. Decode can ask whether a source register has a write pending
//   in the buffer.
//
// Ports
//   clk                   clock, all state on rising edge
//   rst                   asynchronous, active-low reset
//   pipe_we/addr/data     write-back stage request (always granted)
//   mc_valid/addr/data    multi-cycle result, handshake with mc_ready
//   mc_ready              buffer not full
//   q_addr_a/q_addr_b     decode source-register queries
//   q_busy                a query hits a live buffered entry (combinational)
//   stall_req             registered request to freeze the pipeline
//   rf_we/rf_addr/rf_data registered register-file write port
module wb_port_arbiter #(
    parameter int                 ADDR_W       = 4,
    parameter int                 DATA_W       = 16,
    parameter logic [ADDR_W-1:0]  EMPTY_ADDR   = {ADDR_W{1'b1}},
    parameter int                 STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_addr,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] q_addr_a,
    input  logic [ADDR_W-1:0] q_addr_b,
    output logic              q_busy,
    output logic              stall_req,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Buffer storage; entry 0 is the head.
    logic [1:0]        vld_reg;
    logic [ADDR_W-1:0] addr_reg [2];
    logic [DATA_W-1:0] data_reg [2];
    logic [1:0]        vld_next;
    logic [ADDR_W-1:0] addr_next [2];
    logic [DATA_W-1:0] data_next [2];

    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    logic       pipe_real;
    logic       accept;
    logic       store;
    logic       grant_head;
    logic [1:0] kill;
    logic [1:0] hit;
    logic [1:0] keep;

    assign pipe_real  = pipe_we && (pipe_addr != EMPTY_ADDR);
    assign mc_ready   = !(vld_reg[0] && vld_reg[1]);
    assign accept     = mc_valid && mc_ready;
    // Results for the null register, or already overwritten by this cycle's
    // pipeline write, complete the handshake but are not stored.
    assign store      = accept && (mc_addr != EMPTY_ADDR) &&
                        !(pipe_real && (mc_addr == pipe_addr));
    assign grant_head = !pipe_real && vld_reg[0];

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        assign kill[gi] = vld_reg[gi] && pipe_real && (addr_reg[gi] == pipe_addr);
        assign hit[gi]  = vld_reg[gi] &&
                          (((addr_reg[gi] == q_addr_a) && (q_addr_a != EMPTY_ADDR)) ||
                           ((addr_reg[gi] == q_addr_b) && (q_addr_b != EMPTY_ADDR)));
    end

    assign keep[0] = vld_reg[0] && !kill[0] && !grant_head;
    assign keep[1] = vld_reg[1] && !kill[1];
    assign q_busy  = |hit;

    // Survivors compact toward the head, the new result goes behind them.
    // All three cannot coexist because acceptance requires a free slot.
    always_comb begin
        vld_next     = 2'b00;
        addr_next[0] = addr_reg[0];
        addr_next[1] = addr_reg[1];
        data_next[0] = data_reg[0];
        data_next[1] = data_reg[1];
        if (keep[0]) begin
            vld_next[0] = 1'b1;
            if (keep[1]) begin
                vld_next[1] = 1'b1;
            end else if (store) begin
                vld_next[1]  = 1'b1;
                addr_next[1] = mc_addr;
                data_next[1] = mc_data;
            end
        end else if (keep[1]) begin
            vld_next[0]  = 1'b1;
            addr_next[0] = addr_reg[1];
            data_next[0] = data_reg[1];
            if (store) begin
                vld_next[1]  = 1'b1;
                addr_next[1] = mc_addr;
                data_next[1] = mc_data;
            end
        end else if (store) begin
            vld_next[0]  = 1'b1;
            addr_next[0] = mc_addr;
            data_next[0] = mc_data;
        end
    end

    // Counts cycles the current head sat valid without being written or
    // killed; anything else restarts it.
    always_comb begin
        cnt_next = 4'd0;
        if (vld_reg[0] && !grant_head && !kill[0])
            cnt_next = (cnt_reg == 4'hF) ? cnt_reg : cnt_reg + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_reg <= 2'b00;
            cnt_reg <= 4'd0;
            for (int i = 0; i < 2; i++) begin
                addr_reg[i] <= EMPTY_ADDR;
                data_reg[i] <= '0;
            end
        end else begin
            vld_reg <= vld_next;
            cnt_reg <= cnt_next;
            for (int i = 0; i < 2; i++) begin
                addr_reg[i] <= addr_next[i];
                data_reg[i] <= data_next[i];
            end
        end
    end

    // Write port and stall. stall_req looks at the counter before this
    // cycle's update, so it drops one cycle after the head is served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we     <= 1'b0;
            rf_addr   <= EMPTY_ADDR;
            rf_data   <= '0;
            stall_req <= 1'b0;
        end else begin
            stall_req <= (cnt_reg >= LIMIT);
            if (pipe_real) begin
                rf_we   <= 1'b1;
                rf_addr <= pipe_addr;
                rf_data <= pipe_data;
            end else if (vld_reg[0]) begin
                rf_we   <= 1'b1;
                rf_addr <= addr_reg[0];
                rf_data <= data_reg[0];
            end else begin
                rf_we   <= 1'b0;
                rf_addr <= EMPTY_ADDR;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int L = 4;
    localparam logic [3:0] EA = 4'hF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pipe_we = 1'b0;
    logic [3:0]  pipe_addr = 4'h0;
    logic [15:0] pipe_data = 16'h0;
    logic        mc_valid = 1'b0;
    logic [3:0]  mc_addr = 4'h0;
    logic [15:0] mc_data = 16'h0;
    logic        mc_ready;
    logic [3:0]  q_addr_a = EA;
    logic [3:0]  q_addr_b = EA;
    logic        q_busy;
    logic        stall_req;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [15:0] rf_data;

    int n_vec = 0;
    int n_err = 0;

    wb_port_arbiter #(
        .ADDR_W(4), .DATA_W(16), .EMPTY_ADDR(EA), .STARVE_LIMIT(L)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data),
        .mc_ready(mc_ready),
        .q_addr_a(q_addr_a), .q_addr_b(q_addr_b), .q_busy(q_busy),
        .stall_req(stall_req),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pending results as an ordered list.
    typedef struct { logic [3:0] a; logic [15:0] d; } ent_t;
    ent_t        mq[$];
    int          m_wait;
    logic        m_stall;
    logic        m_we;
    logic [3:0]  m_addr;
    logic [15:0] m_data;

    task automatic model_reset();
        mq.delete();
        m_wait  = 0;
        m_stall = 1'b0;
        m_we    = 1'b0;
        m_addr  = EA;
        m_data  = 16'h0;
    endtask

    function automatic logic model_busy(input logic [3:0] qa, input logic [3:0] qb);
        foreach (mq[i])
            if ((qa != EA && mq[i].a == qa) || (qb != EA && mq[i].a == qb)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic pwe, input logic [3:0] pa, input logic [15:0] pd,
                              input logic mv, input logic [3:0] ma, input logic [15:0] md);
        logic real_w, had_head, served, can_take;
        ent_t keep_q[$];
        ent_t ne;
        real_w   = pwe && pa != EA;
        had_head = mq.size() > 0;
        can_take = mq.size() < 2;
        served   = 1'b0;
        m_stall  = (m_wait >= L);
        if (real_w) begin
            m_we = 1'b1; m_addr = pa; m_data = pd;
            if (had_head && mq[0].a == pa) served = 1'b1;
            foreach (mq[i]) if (mq[i].a != pa) keep_q.push_back(mq[i]);
            mq = keep_q;
        end else if (had_head) begin
            m_we = 1'b1; m_addr = mq[0].a; m_data = mq[0].d;
            void'(mq.pop_front());
            served = 1'b1;
        end else begin
            m_we = 1'b0; m_addr = EA;
        end
        if (mv && can_take && ma != EA && !(real_w && ma == pa)) begin
            ne.a = ma; ne.d = md;
            mq.push_back(ne);
        end
        if (had_head && !served) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
        else m_wait = 0;
    endtask

    // One clock cycle: drive, check combinational outputs, step the model,
    // then check the registered outputs just after the edge.
    task automatic cyc(input logic pwe, input logic [3:0] pa, input logic [15:0] pd,
                       input logic mv, input logic [3:0] ma, input logic [15:0] md,
                       input logic [3:0] qa, input logic [3:0] qb);
        pipe_we = pwe; pipe_addr = pa; pipe_data = pd;
        mc_valid = mv; mc_addr = ma; mc_data = md;
        q_addr_a = qa; q_addr_b = qb;
        #3;
        check("mc_ready", mc_ready, mq.size() < 2);
        check("q_busy", q_busy, model_busy(qa, qb));
        model_step(pwe, pa, pd, mv, ma, md);
        @(posedge clk);
        #1;
        check("rf_we", rf_we, m_we);
        check("rf_addr", rf_addr, m_addr);
        check("rf_data", rf_data, m_data);
        check("stall_req", stall_req, m_stall);
        $display("cyc t=%0t pwe=%b pa=%h mv=%b ma=%h -> rf_we=%b rf_addr=%h rf_data=%h stall=%b",
                 $time, pwe, pa, mv, ma, rf_we, rf_addr, rf_data, stall_req);
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, EA, EA);
    endtask

    initial begin : main
        int rise_at;
        model_reset();
        #12;
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_addr", rf_addr, 4'hF);
        check("rst_mc_ready", mc_ready, 1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Idle after reset
        idle();
        check("idle_q_busy", q_busy, 0);

        // Single mc result drains two edges after its handshake
        cyc(1'b0, 4'h0, 16'h0, 1'b1, 4'h3, 16'h1234, EA, EA);
        check("mc_lat_edge1", rf_we, 0);
        idle();
        check("mc_lat_addr", rf_addr, 4'h3);
        check("mc_lat_data", rf_data, 16'h1234);
        idle();

        // Fill both entries under pipe traffic, then drain in order
        cyc(1'b1, 4'h1, 16'h0011, 1'b1, 4'h2, 16'h0022, EA, EA);
        cyc(1'b1, 4'h1, 16'h0012, 1'b1, 4'h5, 16'h0055, 4'h5, EA);
        cyc(1'b1, 4'h1, 16'h0013, 1'b0, 4'h0, 16'h0, 4'h5, EA);
        check("full_ready", mc_ready, 0);
        check("full_busy", q_busy, 1);
        idle();
        check("drain_first", rf_addr, 4'h2);
        idle();
        check("drain_second", rf_addr, 4'h5);
        repeat (3) idle();

        // WAW kill of a buffered entry
        cyc(1'b1, 4'h1, 16'h0001, 1'b1, 4'h4, 16'hAAAA, EA, EA);
        cyc(1'b1, 4'h4, 16'hBEEF, 1'b0, 4'h0, 16'h0, EA, EA);
        check("kill_data", rf_data, 16'hBEEF);
        idle();
        check("kill_no_stale", rf_we, 0);

        // Starvation: stall rises L+1 edges after the head becomes valid
        cyc(1'b1, 4'h1, 16'h0001, 1'b1, 4'h6, 16'h6666, EA, EA);
        rise_at = 0;
        for (int k = 1; k <= 8 && rise_at == 0; k++) begin
            cyc(1'b1, 4'h1, 16'(k), 1'b0, 4'h0, 16'h0, EA, EA);
            if (stall_req) rise_at = k;
        end
        check("stall_rise", rise_at, L + 1);
        idle();
        check("starve_grant", rf_addr, 4'h6);
        idle();
        check("stall_clear", stall_req, 0);

        // Asynchronous reset with two entries buffered
        cyc(1'b1, 4'h1, 16'h0001, 1'b1, 4'h7, 16'h7777, EA, EA);
        cyc(1'b1, 4'h1, 16'h0002, 1'b1, 4'h8, 16'h8888, EA, EA);
        pipe_we = 1'b0; mc_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_rf_we", rf_we, 0);
        check("arst_rf_addr", rf_addr, 4'hF);
        check("arst_rf_data", rf_data, 0);
        check("arst_stall", stall_req, 0);
        check("arst_ready", mc_ready, 1);
        model_reset();
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        repeat (3) idle();

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            logic        pwe, mv;
            logic [3:0]  pa, ma, qa, qb;
            int          r;
            if (stall_req) pwe = ($urandom_range(0, 9) == 0);
            else           pwe = ($urandom_range(0, 9) < 5);
            r  = $urandom_range(0, 8); pa = (r == 8) ? EA : 4'(r);
            r  = $urandom_range(0, 8); ma = (r == 8) ? EA : 4'(r);
            mv = ($urandom_range(0, 9) < 4);
            qa = 4'($urandom_range(0, 15));
            qb = 4'($urandom_range(0, 15));
            cyc(pwe, pa, 16'($urandom), mv, ma, 16'($urandom), qa, qb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
